// File: rtl/nim_score_display_if.sv
// Button/display bus of the N-player score-and-display block.
// The game side drives the buttons and clear; the display side returns
// the segment/anode drive plus the packed BCD scores and game result.
interface nim_score_display_if #(
    parameter int N_PLAYERS         = 2,
    parameter int DIGITS_PER_PLAYER = 2
);
    localparam int NUM_DIGITS = N_PLAYERS * DIGITS_PER_PLAYER;

    logic [N_PLAYERS-1:0]    i_btn;
    logic                    i_clr;
    logic [6:0]              o_seg;
    logic                    o_dp;
    logic [NUM_DIGITS-1:0]   o_an;
    logic [NUM_DIGITS*4-1:0] o_score;
    logic                    o_done;
    logic [1:0]              o_winner;

    modport master (
        output i_btn, i_clr,
        input  o_seg, o_dp, o_an, o_score, o_done, o_winner
    );

    modport slave (
        input  i_btn, i_clr,
        output o_seg, o_dp, o_an, o_score, o_done, o_winner
    );
endinterface

// File: rtl/nim_score_display.sv
// N-player button scoreboard: per-player synchroniser, debouncer and BCD
// press counter with win detection, plus a scanned active-low 7-segment
// display that time-multiplexes every player's digits.
module nim_score_display #(
    parameter int N_PLAYERS         = 2,
    parameter int DIGITS_PER_PLAYER = 2,
    parameter int DEBOUNCE_CNT      = 1000000,
    parameter int REFRESH_CNT       = 100000,
    parameter int WIN_SCORE         = 21,
    parameter bit WRAP              = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    nim_score_display_if.slave bus
);
    localparam int NUM_DIGITS = N_PLAYERS * DIGITS_PER_PLAYER;
    localparam int PW         = DIGITS_PER_PLAYER * 4;
    localparam int SW         = NUM_DIGITS * 4;
    localparam int DB_W       = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam int RF_W       = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CNT - 1);
    localparam logic [RF_W-1:0]  RF_MAX  = RF_W'(REFRESH_CNT - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    // Decimal value to packed BCD, LSD in the low nibble.
    function automatic logic [PW-1:0] to_bcd(input int value);
        logic [PW-1:0] r;
        int v;
        r = '0;
        v = value;
        for (int d = 0; d < DIGITS_PER_PLAYER; d++) begin
            r[d*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    localparam logic [PW-1:0] WIN_BCD = to_bcd(WIN_SCORE);

    // BCD +1 with ripple carry; the carry out of the top digit is dropped,
    // which gives the 99..9 -> 00..0 wrap for free.
    function automatic logic [PW-1:0] bcd_inc(input logic [PW-1:0] v);
        logic [PW-1:0] r;
        logic carry;
        r = v;
        carry = 1'b1;
        for (int d = 0; d < DIGITS_PER_PLAYER; d++) begin
            if (carry) begin
                if (r[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Active-low segment pattern {a,b,c,d,e,f,g}; anything non-BCD is blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] s;
        case (digit)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [N_PLAYERS-1:0] sync1;
    logic [N_PLAYERS-1:0] sync2;
    logic [N_PLAYERS-1:0] deb;
    logic [N_PLAYERS-1:0] press;
    logic [DB_W-1:0]      db_cnt [N_PLAYERS];

    logic [SW-1:0]        score_q;
    logic [SW-1:0]        score_d;
    logic                 done_q;
    logic                 done_d;
    logic [1:0]           winner_q;
    logic [1:0]           winner_d;

    logic [RF_W-1:0]      refresh_cnt;
    logic                 tick;
    logic                 active;
    logic [IDX_W-1:0]     scan_idx;
    logic [IDX_W-1:0]     cur_idx;
    logic [IDX_W-1:0]     sel;
    logic                 disp_on;
    logic [3:0]           digit;
    logic [IDX_W-1:0]     dp_digit;

    logic [NUM_DIGITS-1:0] an_q;
    logic [6:0]           seg_q;
    logic                 dp_q;

    // Two-flop synchroniser for the raw asynchronous buttons.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.i_btn;
            sync2 <= sync1;
        end
    end

    // Debounce: a level must differ for DEBOUNCE_CNT cycles in a row to be accepted; a rising acceptance emits a one-cycle press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb   <= '0;
            press <= '0;
            for (int p = 0; p < N_PLAYERS; p++) begin
                db_cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < N_PLAYERS; p++) begin
                press[p] <= 1'b0;
                if (sync2[p] != deb[p]) begin
                    if (db_cnt[p] == DB_MAX) begin
                        deb[p]    <= sync2[p];
                        press[p]  <= sync2[p];
                        db_cnt[p] <= '0;
                    end else begin
                        db_cnt[p] <= db_cnt[p] + 1'b1;
                    end
                end else begin
                    db_cnt[p] <= '0;
                end
            end
        end
    end

    // Next score/result: clear wins over presses; presses are frozen once the game is over.
    always_comb begin
        score_d  = score_q;
        done_d   = done_q;
        winner_d = winner_q;
        if (bus.i_clr) begin
            score_d  = '0;
            done_d   = 1'b0;
            winner_d = 2'd0;
        end else if (WRAP || !done_q) begin
            for (int p = 0; p < N_PLAYERS; p++) begin
                if (press[p] && (WRAP || score_q[p*PW +: PW] != WIN_BCD)) begin
                    score_d[p*PW +: PW] = bcd_inc(score_q[p*PW +: PW]);
                end
            end
            if (!WRAP) begin
                for (int p = N_PLAYERS - 1; p >= 0; p--) begin
                    if (score_d[p*PW +: PW] == WIN_BCD) begin
                        done_d   = 1'b1;
                        winner_d = 2'(p);
                    end
                end
            end
        end
    end

    // Score and game-result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            score_q  <= '0;
            done_q   <= 1'b0;
            winner_q <= 2'd0;
        end else begin
            score_q  <= score_d;
            done_q   <= done_d;
            winner_q <= winner_d;
        end
    end

    // Refresh timer; each terminal count lights the digit at scan_idx on the next clock and moves the scan on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_cnt <= '0;
            tick        <= 1'b0;
            active      <= 1'b0;
            scan_idx    <= '0;
            cur_idx     <= '0;
        end else begin
            if (refresh_cnt == RF_MAX) begin
                refresh_cnt <= '0;
                tick        <= 1'b1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
                tick        <= 1'b0;
            end
            if (tick) begin
                cur_idx  <= scan_idx;
                active   <= 1'b1;
                scan_idx <= (scan_idx == IDX_MAX) ? '0 : scan_idx + 1'b1;
            end
        end
    end

    // Digit selected for the display registers and the digit that carries the winner's point.
    always_comb begin
        sel      = tick ? scan_idx : cur_idx;
        disp_on  = active | tick;
        digit    = score_q[{sel, 2'b00} +: 4];
        dp_digit = IDX_W'(int'(winner_q) * DIGITS_PER_PLAYER);
    end

    // Registered display drive; blank until the first digit is enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_q  <= '1;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= disp_on ? ~(NUM_DIGITS'(1) << sel) : '1;
            seg_q <= disp_on ? seg_decode(digit) : 7'h7F;
            dp_q  <= (disp_on && done_q && sel == dp_digit) ? 1'b0 : 1'b1;
        end
    end

    assign bus.o_an     = an_q;
    assign bus.o_seg    = seg_q;
    assign bus.o_dp     = dp_q;
    assign bus.o_score  = score_q;
    assign bus.o_done   = done_q;
    assign bus.o_winner = winner_q;
endmodule

// File: doc/nim_score_display.md
Name: nim_score_display

Overview:
- Parametrised score-and-display block for N-player button games.
- Per player: debounces a push-button, counts presses in BCD, and detects the win condition.
- Time-multiplexes all players' digits onto one active-low seven-segment bus with scanned anodes.
- Successor to the fixed two-button, four-digit scoreboard/display pair; replaces always-off anodes with real scanning.

Parameters:
- N_PLAYERS, 2, number of players / button channels (1..4).
- DIGITS_PER_PLAYER, 2, BCD digits per player score (1..4); NUM_DIGITS = N_PLAYERS*DIGITS_PER_PLAYER.
- DEBOUNCE_CNT, 1000000, consecutive stable clk samples required to accept a button level change.
- REFRESH_CNT, 100000, clk cycles each digit is lit before the scan advances.
- WIN_SCORE, 21, decimal score that ends the game; must be < 10**DIGITS_PER_PLAYER.
- WRAP, 0, 0 = saturate at WIN_SCORE; 1 = score wraps to 0 past 10**DIGITS_PER_PLAYER-1 and win detection is disabled.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- i_btn  in  N_PLAYERS  raw asynchronous buttons, active-high, bit p = player p.
- i_clr  in  1  synchronous game clear, active-high, level.
- o_seg  out  7  segments {a,b,c,d,e,f,g}, active-low.
- o_dp  out  1  decimal point, active-low.
- o_an  out  NUM_DIGITS  digit anodes, active-low, one-hot-cold when scanning.
- o_score  out  N_PLAYERS*DIGITS_PER_PLAYER*4  packed BCD scores; player p at bits [p*D*4 +: D*4].
- o_done  out  1  game over.
- o_winner  out  2  index of winning player, valid when o_done=1.

Behaviour:
- Reset (rst=0, async):
  - all scores 0; synchronisers and debounced levels 0; debounce counters 0.
  - scan index 0; refresh counter 0.
  - o_an all 1s, o_seg 7'h7F, o_dp 1, o_done 0, o_winner 0.
  - Release is sampled on clk; no pulses are generated from reset release.
- Input path per player:
  - 2-FF synchroniser.
  - Debouncer: counter increments while synced level != debounced level, clears when equal. On reaching DEBOUNCE_CNT-1, debounced level flips and counter clears.
  - Rising edge of debounced level produces a one-clk press pulse.
  - Press pulse is latency 2 + DEBOUNCE_CNT clk after a clean input edge.
- Score update, registered, one cycle after the press pulse:
  - BCD increment with ripple carry across digits.
  - WRAP=0: no increment once score == WIN_SCORE or o_done=1.
  - WRAP=1: 99..9 -> 00..0.
  - Simultaneous presses on several players all increment in the same cycle.
- Win detection (WRAP=0):
  - The cycle any score becomes WIN_SCORE, o_done<=1 and o_winner<=that index; lowest index wins if several reach it together.
  - o_done holds until i_clr or reset; all presses are ignored while o_done=1.
- i_clr=1:
  - scores <= 0, o_done <= 0, o_winner <= 0.
  - Has priority over a same-cycle press.
  - Debouncers and scan are not affected.
- Scan:
  - Refresh counter counts 0..REFRESH_CNT-1; on terminal count, scan index advances (wraps NUM_DIGITS-1 -> 0).
  - Digit k maps to player k/DIGITS_PER_PLAYER, BCD digit k%DIGITS_PER_PLAYER (digit 0 = player 0 LSD, rightmost).
  - o_an, o_seg, o_dp are registered, one clk after the index change; o_an has exactly one 0 bit.
  - First digit enable occurs REFRESH_CNT+1 clk after reset release.
- Decode:
  - 0 -> 7'b0000001, 1 -> 7'b1001111, 2 -> 7'b0010010, 3 -> 7'b0000110, 4 -> 7'b1001100.
  - 5 -> 7'b0100100, 6 -> 7'b0100000, 7 -> 7'b0001111, 8 -> 7'b0000000, 9 -> 7'b0000100.
  - Non-BCD codes -> 7'h7F.
- o_dp = 0 on the winner's LSD while o_done=1, else 1.
- Mid-operation reset clears everything immediately, including partially debounced presses.

Test Plan:
- Params D=2, N=2, DEBOUNCE_CNT=4, REFRESH_CNT=2, WIN_SCORE=3.
- Reset release, no input -> o_an cycles 1110, 1101, 1011, 0111, 1110, each 2 clk; o_seg=7'b0000001 throughout; o_done=0.
- i_btn[0] bounces (1-clk glitches) then holds high 10 clk -> exactly one increment; o_score[7:0]=8'h01; glitches shorter than 4 clk produce none.
- Both buttons pressed same cycle, three clean presses each -> both scores 8'h03 in the same cycle; o_done=1, o_winner=0; o_dp=0 only while o_an=1110.
- Further presses after o_done -> scores unchanged; assert i_clr with concurrent press -> scores 0, o_done 0.
- WRAP=1, player 1 from 8'h99 plus one press -> 8'h00, carry correct; 8'h09 plus one press -> 8'h10; o_done stays 0.
- rst low mid-debounce and mid-scan -> o_an=all 1s, o_seg=7'h7F, scores 0 asynchronously; no spurious press after release.
